// File: rtl/decode_stage.sv
// Registered decode stage for the 16-bit ARM-style core. It decodes instr[15:11]
// into control and register-select fields. A per-register pending-write
// scoreboard stalls the input on RAW hazards, on WAW hazards when enabled, and
// when a register's pending counter is saturated.
module decode_stage #(
  parameter int WB_PORTS     = 2,
  parameter int PEND_W       = 2,
  parameter bit STALL_ON_WAW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_cond_update,
  output logic                  out_mem_wr,
  output logic                  out_mem_rd,
  output logic                  out_reg_wr,
  output logic                  out_illegal,
  output logic [2:0]            out_wSel,
  output logic [2:0]            out_aSel,
  output logic [2:0]            out_bSel,
  output logic [4:0]            out_imm5,
  output logic [7:0]            out_imm8,
  output logic [10:0]           out_imm11,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [3*WB_PORTS-1:0] wb_sel,
  input  logic                  flush,
  output logic                  wb_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [4:0]        op;
  logic              d_cond_update, d_mem_wr, d_mem_rd, d_reg_wr, d_illegal;
  logic              d_rd_a, d_rd_b;
  logic [2:0]        d_wsel, d_asel, d_bsel;
  logic              hazard, accept;
  logic [PEND_W-1:0] pend     [8];
  logic [PEND_W-1:0] pend_nxt [8];
  logic              err_nxt;

  assign op = in_instr[15:11];

  // Decode the opcode class into enables, register selects and read flags
  always_comb begin
    d_cond_update = 1'b0;
    d_mem_wr      = 1'b0;
    d_mem_rd      = 1'b0;
    d_reg_wr      = 1'b0;
    d_illegal     = 1'b0;
    d_rd_a        = 1'b0;
    d_rd_b        = 1'b0;
    d_wsel        = '0;
    d_asel        = '0;
    d_bsel        = '0;
    if (op <= 5'h0B) begin
      d_wsel        = in_instr[2:0];
      d_asel        = in_instr[5:3];
      d_bsel        = in_instr[8:6];
      d_rd_a        = 1'b1;
      d_rd_b        = 1'b1;
      d_reg_wr      = 1'b1;
      d_cond_update = 1'b1;
    end else if (op <= 5'h0F) begin
      d_wsel        = in_instr[2:0];
      d_asel        = in_instr[5:3];
      d_rd_a        = 1'b1;
      d_reg_wr      = 1'b1;
      d_cond_update = 1'b1;
    end else begin
      case (op)
        5'h10: begin
          d_wsel        = in_instr[10:8];
          d_reg_wr      = 1'b1;
          d_cond_update = 1'b1;
        end
        5'h11, 5'h12: begin
          d_wsel        = in_instr[10:8];
          d_asel        = in_instr[10:8];
          d_rd_a        = 1'b1;
          d_reg_wr      = 1'b1;
          d_cond_update = 1'b1;
        end
        5'h13: begin
          d_asel        = in_instr[10:8];
          d_rd_a        = 1'b1;
          d_cond_update = 1'b1;
        end
        5'h14: begin
          d_wsel   = in_instr[2:0];
          d_asel   = in_instr[5:3];
          d_rd_a   = 1'b1;
          d_reg_wr = 1'b1;
          d_mem_rd = 1'b1;
        end
        5'h15: begin
          d_asel   = in_instr[5:3];
          d_bsel   = in_instr[2:0];
          d_rd_a   = 1'b1;
          d_rd_b   = 1'b1;
          d_mem_wr = 1'b1;
        end
        5'h16, 5'h17: d_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // Hazard detection uses registered counts only; same-cycle retires do not unblock
  always_comb begin
    hazard = (d_rd_a && pend[d_asel] != '0) ||
             (d_rd_b && pend[d_bsel] != '0) ||
             (STALL_ON_WAW && d_reg_wr && pend[d_wsel] != '0) ||
             (d_reg_wr && pend[d_wsel] == PEND_MAX);
  end

  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Net scoreboard update per register: +issue, -each retire, -flushed write; clamp at 0
  always_comb begin
    int unsigned dec;
    int unsigned total;
    err_nxt = 1'b0;
    for (int unsigned r = 0; r < 8; r++) begin
      dec   = 0;
      total = 32'(pend[r]);
      if (accept && d_reg_wr && d_wsel == 3'(r)) total = total + 1;
      for (int unsigned k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && wb_sel[3*k +: 3] == 3'(r)) dec = dec + 1;
      end
      if (flush && out_valid && out_reg_wr && out_wSel == 3'(r)) dec = dec + 1;
      if (total < dec) begin
        pend_nxt[r] = '0;
        err_nxt     = 1'b1;
      end else begin
        pend_nxt[r] = PEND_W'(total - dec);
      end
    end
  end

  // Scoreboard and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < 8; r++) pend[r] <= '0;
      wb_err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 8; r++) pend[r] <= pend_nxt[r];
      wb_err <= err_nxt;
    end
  end

  // One-deep output register: load on accept, hold under backpressure, drop on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_cond_update <= 1'b0;
      out_mem_wr      <= 1'b0;
      out_mem_rd      <= 1'b0;
      out_reg_wr      <= 1'b0;
      out_illegal     <= 1'b0;
      out_wSel        <= '0;
      out_aSel        <= '0;
      out_bSel        <= '0;
      out_imm5        <= '0;
      out_imm8        <= '0;
      out_imm11       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_cond_update <= d_cond_update;
      out_mem_wr      <= d_mem_wr;
      out_mem_rd      <= d_mem_rd;
      out_reg_wr      <= d_reg_wr;
      out_illegal     <= d_illegal;
      out_wSel        <= d_wsel;
      out_aSel        <= d_asel;
      out_bSel        <= d_bsel;
      out_imm5        <= in_instr[10:6];
      out_imm8        <= in_instr[7:0];
      out_imm11       <= in_instr[10:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. It runs two instances on shared stimulus,
// one with WAW stalling and one without. Each instance is compared against a
// per-instance behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        out_ready = 1'b1;
  logic [1:0]  wb_valid = '0;
  logic [5:0]  wb_sel = '0;
  logic        flush = 1'b0;

  logic [1:0]  rdy, ov, cu, mw, mr, rw, ill, err;
  logic [2:0]  ws [2];
  logic [2:0]  as [2];
  logic [2:0]  bs [2];
  logic [4:0]  i5 [2];
  logic [7:0]  i8 [2];
  logic [10:0] i11 [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.WB_PORTS(2), .PEND_W(2), .STALL_ON_WAW(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_instr(in_instr),
    .out_valid(ov[0]), .out_ready(out_ready), .out_cond_update(cu[0]), .out_mem_wr(mw[0]),
    .out_mem_rd(mr[0]), .out_reg_wr(rw[0]), .out_illegal(ill[0]), .out_wSel(ws[0]),
    .out_aSel(as[0]), .out_bSel(bs[0]), .out_imm5(i5[0]), .out_imm8(i8[0]),
    .out_imm11(i11[0]), .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush), .wb_err(err[0])
  );

  decode_stage #(.WB_PORTS(2), .PEND_W(2), .STALL_ON_WAW(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_instr(in_instr),
    .out_valid(ov[1]), .out_ready(out_ready), .out_cond_update(cu[1]), .out_mem_wr(mw[1]),
    .out_mem_rd(mr[1]), .out_reg_wr(rw[1]), .out_illegal(ill[1]), .out_wSel(ws[1]),
    .out_aSel(as[1]), .out_bSel(bs[1]), .out_imm5(i5[1]), .out_imm8(i8[1]),
    .out_imm11(i11[1]), .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush), .wb_err(err[1])
  );

  typedef struct packed {
    logic       cu, mw, mr, rw, ill, ra, rb;
    logic [2:0] w, a, b;
  } dec_t;

  // Reference model state, one set per instance (0 = WAW stall, 1 = no WAW stall)
  int          mp [2][8];
  bit          mv [2];
  dec_t        mo [2];
  logic [15:0] mins [2];
  bit          merr [2];
  bit          mrdy [2];
  localparam int PMAX = 3;

  function automatic dec_t dec(input logic [15:0] ins);
    dec_t d;
    int op;
    d  = '0;
    op = int'(ins[15:11]);
    if (op < 12)                 begin d.w = ins[2:0]; d.a = ins[5:3]; d.b = ins[8:6];
                                       d.ra = 1; d.rb = 1; d.rw = 1; d.cu = 1; end
    else if (op < 16)            begin d.w = ins[2:0]; d.a = ins[5:3]; d.ra = 1; d.rw = 1; d.cu = 1; end
    else if (op == 16)           begin d.w = ins[10:8]; d.rw = 1; d.cu = 1; end
    else if (op == 17 || op == 18) begin d.w = ins[10:8]; d.a = ins[10:8]; d.ra = 1; d.rw = 1; d.cu = 1; end
    else if (op == 19)           begin d.a = ins[10:8]; d.ra = 1; d.cu = 1; end
    else if (op == 20)           begin d.w = ins[2:0]; d.a = ins[5:3]; d.ra = 1; d.rw = 1; d.mr = 1; end
    else if (op == 21)           begin d.a = ins[5:3]; d.b = ins[2:0]; d.ra = 1; d.rb = 1; d.mw = 1; end
    else if (op == 22 || op == 23) d.ill = 1;
    return d;
  endfunction

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, j, obs, exp);
    end
  endtask

  function automatic int pend_of(input int j, input int r);
    return (j == 0) ? int'(u0.pend[r]) : int'(u1.pend[r]);
  endfunction

  // One clock: check in_ready, advance the model at the edge, then check outputs
  task automatic step();
    dec_t d;
    bit   hz, acc, was_rst;
    int   nv, dc;
    #1;
    d = dec(in_instr);
    for (int j = 0; j < 2; j++) begin
      hz = (d.ra && mp[j][d.a] != 0) || (d.rb && mp[j][d.b] != 0) ||
           (d.rw && ((j == 0 && mp[j][d.w] != 0) || mp[j][d.w] == PMAX));
      mrdy[j] = !rst && !flush && !hz && (!mv[j] || out_ready);
      chk("in_ready", j, 32'(rdy[j]), 32'(mrdy[j]));
    end
    @(posedge clk);
    was_rst = rst;
    for (int j = 0; j < 2; j++) begin
      acc = in_valid && mrdy[j];
      if (rst) begin
        for (int r = 0; r < 8; r++) mp[j][r] = 0;
        mv[j] = 0; mo[j] = '0; mins[j] = '0; merr[j] = 0;
      end else begin
        merr[j] = 0;
        for (int r = 0; r < 8; r++) begin
          dc = 0;
          if (wb_valid[0] && int'(wb_sel[2:0]) == r) dc++;
          if (wb_valid[1] && int'(wb_sel[5:3]) == r) dc++;
          if (flush && mv[j] && mo[j].rw && int'(mo[j].w) == r) dc++;
          nv = mp[j][r] + ((acc && d.rw && int'(d.w) == r) ? 1 : 0) - dc;
          if (nv < 0) begin nv = 0; merr[j] = 1; end
          mp[j][r] = nv;
        end
        if (flush) mv[j] = 0;
        else if (acc) begin mv[j] = 1; mo[j] = d; mins[j] = in_instr; end
        else if (out_ready) mv[j] = 0;
      end
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("out_valid", j, 32'(ov[j]), 32'(mv[j]));
      chk("wb_err", j, 32'(err[j]), 32'(merr[j]));
      for (int r = 0; r < 8; r++) chk("pend", j, 32'(pend_of(j, r)), 32'(mp[j][r]));
      if (mv[j] || was_rst) begin
        chk("cond_update", j, 32'(cu[j]), 32'(mo[j].cu));
        chk("mem_wr", j, 32'(mw[j]), 32'(mo[j].mw));
        chk("mem_rd", j, 32'(mr[j]), 32'(mo[j].mr));
        chk("reg_wr", j, 32'(rw[j]), 32'(mo[j].rw));
        chk("illegal", j, 32'(ill[j]), 32'(mo[j].ill));
        chk("wSel", j, 32'(ws[j]), 32'(mo[j].w));
        chk("aSel", j, 32'(as[j]), 32'(mo[j].a));
        chk("bSel", j, 32'(bs[j]), 32'(mo[j].b));
        chk("imm5", j, 32'(i5[j]), was_rst ? 32'd0 : 32'(mins[j][10:6]));
        chk("imm8", j, 32'(i8[j]), was_rst ? 32'd0 : 32'(mins[j][7:0]));
        chk("imm11", j, 32'(i11[j]), was_rst ? 32'd0 : 32'(mins[j][10:0]));
      end
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] ins, input bit ordy,
                       input logic [1:0] wv, input logic [2:0] s0, input logic [2:0] s1,
                       input bit fl, input bit rs);
    in_valid = v; in_instr = ins; out_ready = ordy;
    wb_valid = wv; wb_sel = {s1, s0}; flush = fl; rst = rs;
    step();
  endtask

  initial begin
    for (int j = 0; j < 2; j++) begin
      for (int r = 0; r < 8; r++) mp[j][r] = 0;
      mv[j] = 0; mo[j] = '0; mins[j] = '0; merr[j] = 0;
    end
    // reset
    drive(0, 16'h0000, 1, 2'b00, 0, 0, 0, 1);
    drive(0, 16'h0000, 1, 2'b00, 0, 0, 0, 1);
    // ADD r1 = r2, r3
    drive(1, 16'h00D1, 1, 2'b00, 0, 0, 0, 0);
    chk("add_wsel", 0, 32'(ws[0]), 32'd1);
    chk("add_asel", 0, 32'(as[0]), 32'd2);
    chk("add_bsel", 0, 32'(bs[0]), 32'd3);
    chk("add_pend1", 0, 32'(pend_of(0, 1)), 32'd1);
    // dependent read of r1 stalls; retire cycle itself does not unblock
    drive(1, 16'h080C, 1, 2'b00, 0, 0, 0, 0);
    chk("raw_stall", 0, 32'(rdy[0]), 32'd0);
    drive(1, 16'h080C, 1, 2'b00, 0, 0, 0, 0);
    drive(1, 16'h080C, 1, 2'b01, 1, 0, 0, 0);
    drive(1, 16'h080C, 1, 2'b00, 0, 0, 0, 0);
    chk("raw_asel", 1, 32'(as[1]), 32'd1);
    chk("raw_wsel", 1, 32'(ws[1]), 32'd4);
    // MOV imm8, illegal, branch
    drive(1, 16'h85AB, 1, 2'b00, 0, 0, 0, 0);
    chk("mov_imm8", 1, 32'(i8[1]), 32'hAB);
    drive(1, 16'hB000, 1, 2'b00, 0, 0, 0, 0);
    chk("illegal", 1, 32'(ill[1]), 32'd1);
    drive(1, 16'hC123, 1, 2'b11, 4, 5, 0, 0);
    chk("br_imm11", 1, 32'(i11[1]), 32'h123);
    // four MOV r1: saturation on the non-WAW instance, WAW stall on the other
    for (int i = 0; i < 5; i++) drive(1, 16'h8101, 1, 2'b00, 0, 0, 0, 0);
    chk("sat_pend1", 1, 32'(pend_of(1, 1)), 32'd3);
    chk("sat_stall", 1, 32'(rdy[1]), 32'd0);
    drive(1, 16'h8101, 1, 2'b01, 1, 0, 0, 0);
    drive(1, 16'h8101, 1, 2'b00, 0, 0, 0, 0);
    drive(0, 16'h0000, 1, 2'b11, 1, 1, 0, 0);
    chk("dual_retire", 1, 32'(pend_of(1, 1)), 32'd1);
    drive(0, 16'h0000, 1, 2'b11, 1, 1, 0, 0);
    // backpressure hold then flush
    drive(1, 16'h00D1, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 16'h00D1, 0, 2'b00, 0, 0, 0, 0);
    chk("hold_wsel", 1, 32'(ws[1]), 32'd1);
    drive(0, 16'h0000, 0, 2'b00, 0, 0, 1, 0);
    chk("flush_pend1", 1, 32'(pend_of(1, 1)), 32'd0);
    // retire of an idle register
    drive(0, 16'h0000, 1, 2'b10, 0, 6, 0, 0);
    chk("wb_err_pulse", 1, 32'(err[1]), 32'd1);
    drive(0, 16'h0000, 1, 2'b00, 0, 0, 0, 0);
    // reset while stalled
    drive(1, 16'h00D1, 1, 2'b00, 0, 0, 0, 0);
    drive(1, 16'h080C, 1, 2'b00, 0, 0, 0, 0);
    drive(1, 16'h080C, 1, 2'b00, 0, 0, 0, 1);
    drive(0, 16'h0000, 1, 2'b00, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3) & ($urandom_range(0, 2) == 0 ? 3 : 0)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered instruction-decode stage for the reduced 16-bit ARM-style core, sitting between fetch and execute. It takes a valid/ready instruction stream and decodes the opcode instr[15:11] into control and field outputs. A per-register pending-write scoreboard, cleared by a parametrised number of writeback channels, stalls the stream on read-after-write hazards and optionally on write-after-write hazards. Output is a one-deep registered stage with hold-under-backpressure and flush.

Parameters:
WB_PORTS, 2, number of independent writeback channels (ALU, memory) that retire pending writes
PEND_W, 2, width of each register's pending-write counter; max outstanding writes per register = 2**PEND_W-1
STALL_ON_WAW, 1, 1 = also stall when the destination register has any pending write; 0 = stall only at counter saturation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts this cycle (combinational)
in_instr  in  16  instruction
out_valid  out  1  decoded instruction valid
out_ready  in  1  execute accepts
out_cond_update  out  1  update flags
out_mem_wr  out  1  store
out_mem_rd  out  1  load
out_reg_wr  out  1  register write
out_illegal  out  1  reserved opcode
out_wSel / out_aSel / out_bSel  out  3 each  register selects
out_imm5 / out_imm8 / out_imm11  out  5 / 8 / 11  immediates
wb_valid  in  WB_PORTS  writeback retire strobe per channel
wb_sel  in  3*WB_PORTS  retired register; channel k at [3k+2:3k]
flush  in  1  discard the output register contents
wb_err  out  1  one-cycle pulse on a retire to a register with count 0

Behaviour:
- Fields, always extracted: imm5=[10:6], imm8=[7:0], imm11=[10:0]. aSel/bSel/wSel are set per class below.
- 0x00-0x0B ALU reg-reg: w=[2:0], a=[5:3], b=[8:6]. Reads a and b, writes w, cond_update=1.
- 0x0C-0x0F ALU reg-imm5: w=[2:0], a=[5:3]. Reads a, writes w, cond_update=1.
- 0x10 MOV imm8: w=[10:8]. Writes w, cond_update=1.
- 0x11-0x12 ADD/SUB imm8: w=a=[10:8]. Reads a, writes w, cond_update=1.
- 0x13 CMP imm8: a=[10:8]. Reads a, no write, cond_update=1.
- 0x14 LDR: w=[2:0], a=[5:3]. mem_rd=1, reads a, writes w.
- 0x15 STR: a=[5:3], b=[2:0]. mem_wr=1, reads a and b.
- 0x16-0x17 reserved: illegal=1, all enables 0, no hazard check, no scoreboard change.
- 0x18-0x1F branch: imm11 valid, no register access, all enables 0.
- Unused selects output 0.
- Hazard is computed from registered counts only; a same-cycle retire does not unblock.
  - RAW: any read register has pend!=0.
  - WAW: STALL_ON_WAW=1 and pend[w]!=0.
  - Saturation: pend[w]==2**PEND_W-1.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Decoded result appears registered next cycle (latency 1).
- While out_valid && !out_ready, all outputs hold stable.
- On accept with reg_wr=1 (and not illegal), pend[w] increments.
- Each asserted wb channel decrements pend[wb_sel]. Multiple channels on the same register decrement cumulatively.
- Net update is pend + inc - dec in one cycle.
- A decrement below 0 clamps at 0 and pulses wb_err.
- flush: out_valid<=0 next cycle. If the dropped entry had reg_wr=1, pend[its wSel] is decremented in that same update, so the write is never expected back.
- Reset: out_valid=0, all out_* fields 0, all pend=0, wb_err=0; in_ready=0 while rst is high.
- Reset mid-stall discards everything; there is no replay.

Test Plan:
- ADD 0x00D1 (w=1, a=2, b=3) accepted at cycle 0 -> cycle 1: out_valid=1, reg_wr=1, cond_update=1, wSel=1, aSel=2, bSel=3, pend[1]=1.
- Then 0x080C (reads r1) -> in_ready=0. Pulse wb_valid[0]=1, wb_sel=1 at cycle 3 -> accepted at cycle 4, out aSel=1, wSel=4.
- MOV 0x85AB -> wSel=5, imm8=0xAB, aSel=0. Illegal 0xB000 -> out_illegal=1, enables 0, pend unchanged. Branch 0xC123 -> imm11=0x123.
- STALL_ON_WAW=0, PEND_W=2: four MOV r1 (0x8101) -> three accepted, fourth stalls until any retire on r1. Both wb ports retiring r1 in one cycle -> pend drops by 2.
- out_ready=0 for 3 cycles with 0x00D1 held -> outputs stable, in_ready=0. Then flush -> out_valid=0 next cycle, pend[1] back to 0.
- wb_valid[1]=1 on r6 with pend[6]=0 -> wb_err pulses 1 cycle, pend[6]=0. rst asserted mid-stall -> all pend=0, out_valid=0.
